ad_fifo: RTL and testbench

- Parametrised add/drop elasticity FIFO for the USB2 receive path.
- Sits between the CDR/bit-recovery front end and the NRZI/bit-unstuff stage.
- Absorbs recovered-clock drift: the CDR can add an extra entry in a cycle (two writes) or drop one (no write).
- The consumer pops at most one entry per cycle.
- Includes a start-up fill state machine and sticky overflow/underflow error detection.

---
 rtl/ad_fifo_if.sv | 29 ++
 rtl/ad_fifo.sv | 127 ++++++++++++
 tb/tb_ad_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ad_fifo_if.sv
// Handshake bundle for the add/drop elasticity FIFO: CDR-side writes, consumer pops,
// and status. The master drives requests; the slave is the FIFO itself.
interface ad_fifo_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) ();
  logic                     flush;
  logic                     wr_en;
  logic                     wr_add;
  logic [WIDTH-1:0]         wr_data;
  logic [WIDTH-1:0]         wr_data_add;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   level;
  logic [1:0]               state;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output flush, wr_en, wr_add, wr_data, wr_data_add, rd_en,
    input  rd_data, rd_valid, level, state, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_add, wr_data, wr_data_add, rd_en,
    output rd_data, rd_valid, level, state, overflow, underflow
  );
endinterface

// File: rtl/ad_fifo.sv
// Add/drop elasticity FIFO for the USB2 receive path with start-up fill and sticky errors.
// Optional macro AD_FIFO_ADD_INV_EN: the second entry of an add cycle is stored as ~wr_data.
module ad_fifo #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 8,
  parameter int FILL_LEVEL = DEPTH / 2
) (
  input  logic        clk,
  input  logic        reset,
  ad_fifo_if.slave    bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int LW1 = LW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, ERR = 2'd3} state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_reg, state_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next, wr_ptr_p1;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;

  logic [1:0]       n_w;
  logic             pop_ok, udf_evt, ovf_evt, wr_ok;
  logic             do_pop, do_write, do_second;
  logic [LW1-1:0]   sum;
  logic [WIDTH-1:0] add_data;

`ifdef AD_FIFO_ADD_INV_EN
  assign add_data = ~bus.wr_data;
`else
  assign add_data = bus.wr_data_add;
`endif

  assign wr_ptr_p1 = wr_ptr_reg + PW'(1);

  always_comb begin
    n_w = 2'd0;
    if (bus.wr_en) n_w = bus.wr_add ? 2'd2 : 2'd1;

    // Level compared is the start-of-cycle value, so same-cycle writes never feed a pop
    pop_ok  = (state_reg == RUN) && bus.rd_en && (level_reg != '0);
    udf_evt = (state_reg == RUN) && bus.rd_en && (level_reg == '0);
    sum     = {1'b0, level_reg} - LW1'(pop_ok) + LW1'(n_w);
    ovf_evt = (state_reg != ERR) && (sum > LW1'(DEPTH));
    wr_ok   = (state_reg != ERR) && (n_w != 2'd0) && !ovf_evt && !udf_evt;

    state_next  = state_reg;
    level_next  = level_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    ovf_next    = ovf_reg;
    udf_next    = udf_reg;
    do_pop      = 1'b0;
    do_write    = 1'b0;
    do_second   = 1'b0;

    if (bus.flush) begin
      state_next  = IDLE;
      level_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      ovf_next    = 1'b0;
      udf_next    = 1'b0;
    end else begin
      do_pop    = pop_ok;
      do_write  = wr_ok;
      do_second = wr_ok && (n_w == 2'd2);
      if (pop_ok) rd_ptr_next = rd_ptr_reg + PW'(1);
      if (wr_ok)  wr_ptr_next = wr_ptr_reg + PW'(n_w);
      level_next = level_reg - LW'(pop_ok) + (wr_ok ? LW'(n_w) : '0);

      if (ovf_evt || udf_evt) begin
        state_next = ERR;
        if (ovf_evt) ovf_next = 1'b1;
        if (udf_evt) udf_next = 1'b1;
      end else begin
        case (state_reg)
          IDLE: if (wr_ok) state_next = (level_next >= LW'(FILL_LEVEL)) ? RUN : FILL;
          FILL: if (level_next >= LW'(FILL_LEVEL)) state_next = RUN;
          default: state_next = state_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      level_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      level_reg    <= level_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      ovf_reg      <= ovf_next;
      udf_reg      <= udf_next;
      rd_valid_reg <= do_pop;
      if (do_pop) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (do_write)  mem[wr_ptr_reg] <= bus.wr_data;
    if (do_second) mem[wr_ptr_p1]  <= add_data;
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.level     = level_reg;
  assign bus.state     = state_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.underflow = udf_reg;
endmodule

// File: tb/tb_ad_fifo.sv
// Directed bench for ad_fifo (DEPTH=8, FILL_LEVEL=4): vector tables plus hand sequences
// for the pointer-wrap steady state and the asynchronous reset.
module tb_ad_fifo;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

`ifdef AD_FIFO_ADD_INV_EN
  localparam logic ADD2 = 1'b0;
`else
  localparam logic ADD2 = 1'b1;
`endif

  always #5 clk = ~clk;

  ad_fifo_if #(.WIDTH(1), .DEPTH(8)) bus_if ();

  ad_fifo #(.WIDTH(1), .DEPTH(8), .FILL_LEVEL(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic       fl, we, wa, wd, wda, re;
    logic       rv, rd;
    logic [3:0] lvl;
    logic [1:0] st;
    logic       ov, un;
  } vec_t;

  function automatic vec_t mk(input logic fl, we, wa, wd, wda, re,
                              input logic rv, rd, input int lvl, input int st,
                              input logic ov, un);
    vec_t v;
    v.fl = fl; v.we = we; v.wa = wa; v.wd = wd; v.wda = wda; v.re = re;
    v.rv = rv; v.rd = rd; v.lvl = 4'(lvl); v.st = 2'(st); v.ov = ov; v.un = un;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bus_if.rd_valid, bus_if.rd_data[0], bus_if.level, bus_if.state,
            bus_if.overflow, bus_if.underflow};
  endfunction

  task automatic set_in(input vec_t v);
    bus_if.flush          = v.fl;
    bus_if.wr_en          = v.we;
    bus_if.wr_add         = v.wa;
    bus_if.wr_data[0]     = v.wd;
    bus_if.wr_data_add[0] = v.wda;
    bus_if.rd_en          = v.re;
  endtask

  task automatic check(input string tag, input int idx, input logic [9:0] exp);
    logic [9:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] {rv,rd,lvl,st,ov,un} got=%b want=%b", tag, idx, got, exp);
    end else begin
      $display("ok   %s[%0d] {rv,rd,lvl,st,ov,un}=%b", tag, idx, got);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    set_in(v);
    @(posedge clk);
    #1;
    check(tag, idx, {v.rv, v.rd, v.lvl, v.st, v.ov, v.un});
  endtask

  vec_t t_fill[$];
  vec_t t_err[$];
  vec_t idle_v;
  logic prev;
  logic d;

  initial begin
    // fl we wa wd wda re | rv rd lvl st ov un
    // fill, drain, add cycle across the wrap, drop/steady lead-in
    t_fill.push_back(mk(0,1,0,1,0,0, 0,0,1,1,0,0));
    t_fill.push_back(mk(0,1,0,0,0,0, 0,0,2,1,0,0));
    t_fill.push_back(mk(0,1,0,1,0,0, 0,0,3,1,0,0));
    t_fill.push_back(mk(0,1,0,1,0,0, 0,0,4,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,3,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,0,2,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,1,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,0,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,0, 0,1,0,2,0,0));
    t_fill.push_back(mk(0,1,0,0,0,0, 0,1,1,2,0,0));
    t_fill.push_back(mk(0,1,0,1,0,0, 0,1,2,2,0,0));
    t_fill.push_back(mk(0,1,0,0,0,0, 0,1,3,2,0,0));
    t_fill.push_back(mk(0,1,1,1,1,0, 0,1,5,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,0,4,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,3,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,0,2,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,1,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,ADD2,0,2,0,0));
    t_fill.push_back(mk(0,1,0,1,0,0, 0,ADD2,1,2,0,0));
    t_fill.push_back(mk(0,1,0,0,0,0, 0,ADD2,2,2,0,0));
    t_fill.push_back(mk(0,0,0,0,0,1, 1,1,1,2,0,0));
    t_fill.push_back(mk(0,1,0,1,0,1, 1,0,1,2,0,0));
    t_fill.push_back(mk(0,1,0,0,0,1, 1,1,1,2,0,0));
    t_fill.push_back(mk(0,1,0,1,0,1, 1,0,1,2,0,0));

    // overflow (plain and with a same-cycle pop), flush, underflow, refill to level 5
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,3,2,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,5,2,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,7,2,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,7,3,1,0));
    t_err.push_back(mk(0,1,0,1,0,1, 0,0,7,3,1,0));
    t_err.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    t_err.push_back(mk(0,1,0,1,0,0, 0,0,1,1,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,3,1,0,0));
    t_err.push_back(mk(0,1,1,0,1,0, 0,0,5,2,0,0));
    t_err.push_back(mk(0,1,1,1,1,0, 0,0,7,2,0,0));
    t_err.push_back(mk(0,1,0,0,0,0, 0,0,8,2,0,0));
    t_err.push_back(mk(0,1,1,1,1,1, 1,1,7,3,1,0));
    t_err.push_back(mk(0,1,0,1,0,1, 0,1,7,3,1,0));
    t_err.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0,0));
    t_err.push_back(mk(0,1,1,1,1,0, 0,1,2,1,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,1,4,2,0,0));
    t_err.push_back(mk(0,0,0,0,0,1, 1,1,3,2,0,0));
    t_err.push_back(mk(0,0,0,0,0,1, 1,ADD2,2,2,0,0));
    t_err.push_back(mk(0,0,0,0,0,1, 1,1,1,2,0,0));
    t_err.push_back(mk(0,0,0,0,0,1, 1,0,0,2,0,0));
    t_err.push_back(mk(0,1,0,1,0,1, 0,0,0,3,0,1));
    t_err.push_back(mk(0,0,0,0,0,1, 0,0,0,3,0,1));
    t_err.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    t_err.push_back(mk(0,1,1,1,1,0, 0,0,2,1,0,0));
    t_err.push_back(mk(0,1,1,1,0,0, 0,0,4,2,0,0));
    t_err.push_back(mk(0,1,0,1,0,0, 0,0,5,2,0,0));

    idle_v = mk(0,0,0,0,0,0, 0,0,0,0,0,0);
    set_in(idle_v);
    reset = 1'b1;
    #2;
    check("reset", 0, 10'b0);
    #10;
    reset = 1'b0;

    foreach (t_fill[i]) apply(t_fill[i], "fill", i);

    // steady state: one pop and one write per cycle across several pointer wraps
    prev = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = ((k % 3) == 1);
      apply(mk(0,1,0,d,0,1, 1,prev,1,2,0,0), "steady", k);
      prev = d;
    end

    foreach (t_err[i]) apply(t_err[i], "err", i);

    // asynchronous reset between clock edges while running at level 5
    set_in(idle_v);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst", 0, 10'b0);
    #2;
    reset = 1'b0;

    apply(mk(0,1,0,1,0,0, 0,0,1,1,0,0), "post_rst", 0);
    apply(mk(0,1,1,0,1,0, 0,0,3,1,0,0), "post_rst", 1);
    apply(mk(0,1,0,1,0,0, 0,0,4,2,0,0), "post_rst", 2);
    apply(mk(0,0,0,0,0,1, 1,1,3,2,0,0), "post_rst", 3);
    apply(mk(0,0,0,0,0,1, 1,0,2,2,0,0), "post_rst", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
